// File: rtl/snoopy_mover.sv
// snoopy_mover: player sprite position, per-frame gravity/jump physics and erase/draw redraw
// through a valid/ready pixel plotter. Define SNOOPY_MOVER_FLOOR_HIT_EN to add the sticky
// floor_hit output.
module snoopy_mover #(
  parameter int FRAME_DIV = 833333,
  parameter int SIZE = 4,
  parameter int X_START = 0,
  parameter int Y_START = 56,
  parameter int X_STEP = 1,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int GRAVITY = 1,
  parameter int JUMP_VEL = 6,
  parameter int MAX_FALL = 7,
  parameter logic [2:0] SPRITE_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       jump,
  input  logic       plot_ready,
  output logic       plot_valid,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  output logic [7:0] x_coord,
  output logic [6:0] y_coord,
  output logic       frame_done
`ifdef SNOOPY_MOVER_FLOOR_HIT_EN
  ,
  output logic       floor_hit
`endif
);
  localparam int CW = $clog2(FRAME_DIV + 1);
  localparam int IW = $clog2(SIZE + 1);
  localparam int Y_LIM = Y_MAX - SIZE + 1;
  localparam int SCREEN_X = 159;

  typedef enum logic [2:0] {IDLE, ERASE, UPDATE, DRAW, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [IW-1:0] col, row;
  logic signed [4:0] vel, vel_n;
  logic jump_pending, restart_pending, enable_q;
  logic tick, rise, restart, busy, clip, step, last, floor, top;
  logic [8:0] pix_x, x_s;
  logic signed [8:0] vel_g, vel_c, y_s;
  logic [7:0] x_n;
  logic [6:0] y_n;

  assign tick = cnt == CW'(FRAME_DIV - 1);
  assign rise = enable && !enable_q;
  assign restart = state == IDLE && (rise || restart_pending);
  assign busy = state == ERASE || state == DRAW;
  assign pix_x = {1'b0, x_coord} + 9'(col);
  assign clip = pix_x > 9'(SCREEN_X);
  assign step = busy && (clip || plot_ready);
  assign last = col == IW'(SIZE - 1) && row == IW'(SIZE - 1);
  assign plot_valid = busy && !clip;
  assign plot_x = busy ? pix_x[7:0] : '0;
  assign plot_y = busy ? y_coord + 7'(row) : '0;
  assign plot_colour = state == DRAW ? SPRITE_COLOUR : BG_COLOUR;

  // Next-position physics, evaluated continuously and committed in UPDATE.
  always_comb begin
    vel_g = $signed({{4{vel[4]}}, vel}) + 9'(GRAVITY);
    vel_c = jump_pending ? -9'(JUMP_VEL) : (vel_g > 9'(MAX_FALL) ? 9'(MAX_FALL) : vel_g);
    y_s = $signed({2'b00, y_coord}) + vel_c;
    top = y_s < 9'sd0;
    floor = y_s > 9'(Y_LIM);
    y_n = top ? 7'd0 : floor ? 7'(Y_LIM) : y_s[6:0];
    vel_n = (top || floor) ? 5'sd0 : vel_c[4:0];
    x_s = {1'b0, x_coord} + 9'(X_STEP);
    x_n = x_s > 9'(X_MAX) ? 8'(X_MAX) : x_s[7:0];
  end

  // State register.
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;

  // Frame sequencing: a dropped tick outside IDLE is simply lost.
  always_comb begin
    state_n = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (tick && enable && !restart) state_n = ERASE;
      ERASE:   if (step && last) state_n = UPDATE;
      UPDATE:  state_n = DRAW;
      DRAW:    if (step && last) state_n = DONE;
      DONE:    begin
        state_n = IDLE;
        frame_done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame counter, pixel walker, position/velocity and jump/restart bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      col <= '0;
      row <= '0;
      x_coord <= 8'(X_START);
      y_coord <= 7'(Y_START);
      vel <= '0;
      jump_pending <= 1'b0;
      restart_pending <= 1'b0;
      enable_q <= 1'b0;
`ifdef SNOOPY_MOVER_FLOOR_HIT_EN
      floor_hit <= 1'b0;
`endif
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      enable_q <= enable;
      if (step) begin
        col <= col == IW'(SIZE - 1) ? '0 : col + 1'b1;
        if (col == IW'(SIZE - 1)) row <= row == IW'(SIZE - 1) ? '0 : row + 1'b1;
      end
      if (restart) begin
        x_coord <= 8'(X_START);
        y_coord <= 7'(Y_START);
        vel <= '0;
        jump_pending <= 1'b0;
        restart_pending <= 1'b0;
      end else begin
        if (rise) restart_pending <= 1'b1;
        if (state == UPDATE) begin
          x_coord <= x_n;
          y_coord <= y_n;
          vel <= vel_n;
          jump_pending <= enable && jump;
        end else if (enable && jump) jump_pending <= 1'b1;
      end
`ifdef SNOOPY_MOVER_FLOOR_HIT_EN
      if (enable_q && !enable) floor_hit <= 1'b0;
      else if (state == UPDATE && floor && vel_c > 9'sd0) floor_hit <= 1'b1;
`endif
    end
  end
endmodule
